// File: rtl/card_dealer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : card_dealer
// Brief  : LFSR shuffle with rejection sampling; deals 9 unique cards and
//          hands them to the poker evaluator, latching its verdict.
// Rev    : 1.0  initial release
// ============================================================================
module card_dealer #(
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int          EVAL_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        deal_req,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    input  logic        eval_done,
    input  logic [1:0]  eval_result,
    input  logic [3:0]  eval_hand,
    input  logic        eval_qualify,
    output logic [11:0] playerCards,
    output logic [11:0] dealerCards,
    output logic [29:0] communityCards,
    output logic        start,
    output logic        busy,
    output logic        deal_valid,
    output logic [3:0]  card_count,
    output logic [1:0]  round_result,
    output logic [3:0]  round_hand,
    output logic        round_qualify,
    output logic        round_done,
    output logic        eval_error
);

    localparam logic [15:0] c_lfsr_taps = 16'hB400;
    localparam logic [5:0]  c_deck_size = 6'd52;
    localparam logic [3:0]  c_last_slot = 4'd8;
    localparam int          c_wait_w    = $clog2(EVAL_TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(EVAL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_lfsr;
    logic [51:0]           r_used;
    logic [3:0]            r_count;
    logic [5:0]            r_slot [0:8];
    logic                  r_deal_valid;
    logic [1:0]            r_round_result;
    logic [3:0]            r_round_hand;
    logic                  r_round_qualify;
    logic                  r_round_done;
    logic                  r_eval_error;
    logic [c_wait_w-1:0]   r_wait_cnt;

    logic [15:0]           w_lfsr_nxt;
    logic [5:0]            w_cand;
    logic [63:0]           w_used_ext;
    logic                  w_accept;
    logic                  w_timeout;

    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 16'h0000);
    assign w_cand     = r_lfsr[5:0];
    // Zero-padding keeps the lookup in range for the rejected codes 52..63
    assign w_used_ext = {12'h000, r_used};
    assign w_accept   = (w_cand < c_deck_size) && !w_used_ext[w_cand];
    assign w_timeout  = (r_wait_cnt == c_wait_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        start       = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (deal_req) begin
                    w_state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                if (w_accept && (r_count == c_last_slot)) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start       = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (eval_done || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr          <= SEED;
            r_used          <= '0;
            r_count         <= '0;
            r_slot          <= '{default: '0};
            r_deal_valid    <= 1'b0;
            r_round_result  <= '0;
            r_round_hand    <= '0;
            r_round_qualify <= 1'b0;
            r_round_done    <= 1'b0;
            r_eval_error    <= 1'b0;
            r_wait_cnt      <= '0;
        end else begin
            r_round_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (seed_load) begin
                        r_lfsr <= (seed_in == 16'h0000) ? SEED : seed_in;
                    end
                    if (deal_req) begin
                        r_used       <= '0;
                        r_count      <= '0;
                        r_deal_valid <= 1'b0;
                        r_eval_error <= 1'b0;
                    end
                end
                S_DRAW: begin
                    r_lfsr <= w_lfsr_nxt;
                    if (w_accept) begin
                        r_slot[r_count] <= w_cand;
                        r_used[w_cand]  <= 1'b1;
                        r_count         <= r_count + 4'd1;
                        // Raised with the last card so it is already high in ISSUE
                        if (r_count == c_last_slot) begin
                            r_deal_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (eval_done) begin
                        r_round_result  <= eval_result;
                        r_round_hand    <= eval_hand;
                        r_round_qualify <= eval_qualify;
                        r_round_done    <= 1'b1;
                    end else if (w_timeout) begin
                        r_eval_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign playerCards    = {r_slot[0], r_slot[1]};
    assign dealerCards    = {r_slot[2], r_slot[3]};
    assign communityCards = {r_slot[4], r_slot[5], r_slot[6], r_slot[7], r_slot[8]};
    assign deal_valid     = r_deal_valid;
    assign card_count     = r_count;
    assign round_result   = r_round_result;
    assign round_hand     = r_round_hand;
    assign round_qualify  = r_round_qualify;
    assign round_done     = r_round_done;
    assign eval_error     = r_eval_error;

endmodule

`default_nettype wire

// File: tb/tb_card_dealer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_card_dealer
// Brief  : Randomised scoreboard bench for card_dealer against a deck model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_card_dealer;

    localparam logic [15:0] c_seed = 16'hACE1;

    typedef struct packed {
        logic [11:0] p;
        logic [11:0] d;
        logic [29:0] c;
    } deal_t;

    typedef struct packed {
        logic [1:0] res;
        logic [3:0] hand;
        logic       qual;
    } round_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        deal_req = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic        eval_done = 1'b0;
    logic [1:0]  eval_result = 2'd0;
    logic [3:0]  eval_hand = 4'd0;
    logic        eval_qualify = 1'b0;
    logic [11:0] playerCards;
    logic [11:0] dealerCards;
    logic [29:0] communityCards;
    logic        start;
    logic        busy;
    logic        deal_valid;
    logic [3:0]  card_count;
    logic [1:0]  round_result;
    logic [3:0]  round_hand;
    logic        round_qualify;
    logic        round_done;
    logic        eval_error;

    card_dealer #(.SEED(16'hACE1), .EVAL_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .deal_req(deal_req), .seed_load(seed_load),
        .seed_in(seed_in), .eval_done(eval_done), .eval_result(eval_result),
        .eval_hand(eval_hand), .eval_qualify(eval_qualify),
        .playerCards(playerCards), .dealerCards(dealerCards),
        .communityCards(communityCards), .start(start), .busy(busy),
        .deal_valid(deal_valid), .card_count(card_count),
        .round_result(round_result), .round_hand(round_hand),
        .round_qualify(round_qualify), .round_done(round_done),
        .eval_error(eval_error)
    );

    always #5 clk = ~clk;

    deal_t       exp_deal [$];
    round_t      exp_round [$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_start = 0;
    logic [15:0] m_lfsr = c_seed;
    round_t      last_round = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Deck model: walk the LFSR sequence, keep the first 9 distinct values below 52
    function automatic deal_t model_deal(input logic [15:0] seed, output logic [15:0] final_s);
        bit          seen [52];
        logic [5:0]  cards [9];
        logic [15:0] s;
        int          n;
        int          v;
        deal_t       d;
        for (int i = 0; i < 52; i++) seen[i] = 1'b0;
        s = seed;
        n = 0;
        while (n < 9) begin
            v = int'(s[5:0]);
            if (v < 52) begin
                if (!seen[v]) begin
                    seen[v]  = 1'b1;
                    cards[n] = s[5:0];
                    n++;
                end
            end
            s = lfsr_step(s);
        end
        final_s = s;
        d.p = {cards[0], cards[1]};
        d.d = {cards[2], cards[3]};
        d.c = {cards[4], cards[5], cards[6], cards[7], cards[8]};
        return d;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a deal or a verdict
    logic       prev_start = 1'b0;
    deal_t      mon_d;
    round_t     mon_r;
    logic [5:0] mon_cards [9];
    int         mon_bad;

    always @(negedge clk) begin
        if (start) begin
            n_start++;
            chk("start_width", prev_start, 1'b0);
            chk("deal_valid_at_start", deal_valid, 1'b1);
            chk("card_count_at_start", card_count, 4'd9);
            if (exp_deal.size() == 0) begin
                fail_now("unexpected_start");
            end else begin
                mon_d = exp_deal.pop_front();
                chk("player_bus", playerCards, mon_d.p);
                chk("dealer_bus", dealerCards, mon_d.d);
                chk("community_bus", communityCards, mon_d.c);
            end
            mon_cards[0] = playerCards[11:6];    mon_cards[1] = playerCards[5:0];
            mon_cards[2] = dealerCards[11:6];    mon_cards[3] = dealerCards[5:0];
            mon_cards[4] = communityCards[29:24]; mon_cards[5] = communityCards[23:18];
            mon_cards[6] = communityCards[17:12]; mon_cards[7] = communityCards[11:6];
            mon_cards[8] = communityCards[5:0];
            mon_bad = 0;
            for (int i = 0; i < 9; i++) begin
                if (mon_cards[i] > 6'd51) mon_bad++;
                for (int j = 0; j < i; j++) if (mon_cards[i] == mon_cards[j]) mon_bad++;
            end
            chk("cards_legal_unique", mon_bad, 0);
        end
        if (round_done) begin
            chk("busy_at_round_done", busy, 1'b0);
            if (exp_round.size() == 0) begin
                fail_now("unexpected_round_done");
            end else begin
                mon_r = exp_round.pop_front();
                chk("round_fields", {round_result, round_hand, round_qualify}, mon_r);
            end
        end
        prev_start = start;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_outputs"},
            {playerCards, dealerCards, communityCards, start, busy, deal_valid,
             card_count, round_result, round_hand, round_qualify, round_done, eval_error}, 64'd0);
    endtask

    task automatic do_deal(input bit load, input logic [15:0] seed, input bit respond,
                           input bit inject, input logic [1:0] res, input logic [3:0] hand,
                           input logic qual);
        deal_t       d;
        round_t      r;
        logic [15:0] fin;
        int          s0;
        int          cyc;
        bit          seen;
        if (load) m_lfsr = (seed == 16'h0000) ? c_seed : seed;
        d = model_deal(m_lfsr, fin);
        m_lfsr = fin;
        exp_deal.push_back(d);
        r.res = res; r.hand = hand; r.qual = qual;
        if (respond) exp_round.push_back(r);
        s0 = n_start;
        deal_req = 1'b1; seed_load = load; seed_in = seed;
        @(posedge clk); #1;
        deal_req = 1'b0; seed_load = 1'b0;
        @(negedge clk);
        chk("busy_after_req", busy, 1'b1);
        chk("deal_valid_cleared", deal_valid, 1'b0);
        chk("eval_error_cleared", eval_error, 1'b0);
        if (inject) begin
            deal_req = 1'b1; seed_load = 1'b1; seed_in = 16'h1234;
            @(posedge clk); #1;
            deal_req = 1'b0; seed_load = 1'b0;
        end
        seen = 1'b0;
        for (cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            if (start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            fail_now("start_timeout");
            return;
        end
        if (respond) begin
            @(posedge clk); #1;
            eval_done = 1'b1; eval_result = res; eval_hand = hand; eval_qualify = qual;
            @(posedge clk); #1;
            eval_done = 1'b0;
            eval_result = 2'($urandom_range(0, 3)); eval_hand = 4'($urandom);
            eval_qualify = 1'($urandom);
            @(negedge clk);
            chk("busy_after_done", busy, 1'b0);
            @(negedge clk);
            chk("round_hold", {round_result, round_hand, round_qualify}, r);
            last_round = r;
        end else begin
            cyc = 0;
            while (!eval_error && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            chk("timeout_cycles", cyc, 17);
            chk("busy_after_timeout", busy, 1'b0);
            chk("round_kept_on_timeout", {round_result, round_hand, round_qualify}, last_round);
        end
        chk("starts_per_deal", n_start - s0, 1);
    endtask

    initial begin
        int cyc;
        logic [15:0] rs;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Default seed: 33, 48, then 56 rejected, then 28
        do_deal(1'b0, 16'h0, 1'b1, 1'b0, 2'd1, 4'd4, 1'b1);
        chk("s1_player", playerCards, 12'h870);
        chk("s1_dealer0", dealerCards[11:6], 6'd28);

        // Evaluator silent: timeout, then cleared by the next accepted deal
        do_deal(1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        chk("eval_error_sticky", eval_error, 1'b1);

        // Zero seed load restores the default seed
        seed_in = 16'h0000; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        m_lfsr = c_seed;
        do_deal(1'b0, 16'h0, 1'b1, 1'b0, 2'd2, 4'd9, 1'b0);
        chk("s5_player", playerCards, 12'h870);
        chk("s5_dealer0", dealerCards[11:6], 6'd28);

        // Same-cycle zero seed load and deal request
        do_deal(1'b1, 16'h0, 1'b1, 1'b0, 2'd0, 4'd3, 1'b1);
        chk("s5b_player", playerCards, 12'h870);

        // deal_req and seed_load during DRAW must be ignored
        do_deal(1'b0, 16'h0, 1'b1, 1'b1, 2'd1, 4'd7, 1'b0);
        do_deal(1'b0, 16'h0, 1'b1, 1'b0, 2'd2, 4'd1, 1'b1);

        // Reset in the middle of a deal
        deal_req = 1'b1;
        @(posedge clk); #1;
        deal_req = 1'b0;
        cyc = 0;
        while (card_count != 4'd5 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (card_count != 4'd5) fail_now("reach_count5");
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_deal_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        m_lfsr = c_seed;
        last_round = '0;
        do_deal(1'b0, 16'h0, 1'b1, 1'b0, 2'd1, 4'd2, 1'b1);
        chk("post_reset_player", playerCards, 12'h870);

        // Random seeds, alternating same-cycle and separate seed loads
        for (int k = 0; k < 1000; k++) begin
            rs = 16'($urandom_range(1, 65535));
            if (k % 2 == 0) begin
                do_deal(1'b1, rs, 1'b1, 1'b0, 2'($urandom_range(0, 2)), 4'($urandom),
                        1'($urandom));
            end else begin
                seed_in = rs; seed_load = 1'b1;
                @(posedge clk); #1;
                seed_load = 1'b0;
                m_lfsr = rs;
                do_deal(1'b0, 16'h0, 1'b1, 1'b0, 2'($urandom_range(0, 2)), 4'($urandom),
                        1'($urandom));
            end
        end

        repeat (3) @(negedge clk);
        chk("deal_queue_drained", exp_deal.size(), 0);
        chk("round_queue_drained", exp_round.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
